// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo decoder iteration control path.
// Holds the scheduler state encoding and the LLR-bus field slicing helper.
package turbo_pkg;

  localparam int N_BITS   = 7;
  localparam int LLR_W    = 10;
  localparam int MAX_ITER = 16;
  localparam int ITER_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    FINISH
  } state_e;

  // MSB (sign bit) index of field i; field 0 occupies the top of the bus.
  function automatic int field_msb(input int i, input int n_bits, input int llr_w);
    return (n_bits - i) * llr_w - 1;
  endfunction

endpackage

// File: rtl/llr_sign_slicer.sv
// Extracts the sign bit of every LLR field as a hard decision.
// Field i maps to output bit FIELDS-1-i, so field 0 lands in the MSB.
module llr_sign_slicer
  import turbo_pkg::*;
#(
  parameter int FIELDS  = N_BITS,
  parameter int FIELD_W = LLR_W
) (
  input  logic [FIELDS*FIELD_W-1:0] llr_i,
  output logic [FIELDS-1:0]         sign_o
);

  for (genvar gi = 0; gi < FIELDS; gi++) begin : g_sign
    assign sign_o[FIELDS-1-gi] = llr_i[field_msb(gi, FIELDS, FIELD_W)];
  end

  // Magnitude bits are intentionally dropped; only the signs matter here.
  logic unused_mag;
  assign unused_mag = ^llr_i;

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Half-iteration scheduler for the shared SISO engine: DEC1/DEC2 sequencing,
// iteration counting against a clamped limit, and hard-decision early stop.
module turbo_iter_ctrl #(
  parameter int MAX_ITER = turbo_pkg::MAX_ITER,
  parameter int N_BITS   = turbo_pkg::N_BITS,
  parameter int LLR_W    = turbo_pkg::LLR_W,
  parameter int ITER_W   = turbo_pkg::ITER_W
) (
  input  logic                    clk_p_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [ITER_W-1:0]       max_iter_i,
  input  logic                    early_stop_en_i,
  output logic                    siso_start_o,
  input  logic                    siso_finish_i,
  input  logic [N_BITS*LLR_W-1:0] siso_llr_i,
  output logic                    half_sel_o,
  output logic                    ext_we_o,
  output logic [N_BITS-1:0]       hard_o,
  output logic [ITER_W-1:0]       iter_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    early_o
);

  turbo_pkg::state_e state_q, state_d;

  logic [ITER_W-1:0] lim_q, lim_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iter_inc;
  logic [ITER_W-1:0] lim_in;
  logic              early_en_q, early_en_d;
  logic              half_q, half_d;
  logic              early_q, early_d;
  logic [N_BITS-1:0] prev_hard_q, prev_hard_d;
  logic [N_BITS-1:0] hard_q, hard_d;
  logic [N_BITS-1:0] hard_new;
  logic              siso_start_q, siso_start_d;
  logic              ext_we_q, ext_we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  llr_sign_slicer #(
    .FIELDS  (N_BITS),
    .FIELD_W (LLR_W)
  ) u_slicer (
    .llr_i  (siso_llr_i),
    .sign_o (hard_new)
  );

  assign iter_inc = iter_q + 1'b1;
  assign lim_in   = (max_iter_i == '0)                   ? ITER_W'(1) :
                    (max_iter_i > ITER_W'(MAX_ITER))     ? ITER_W'(MAX_ITER) :
                                                           max_iter_i;

  always_comb begin
    state_d     = state_q;
    lim_d       = lim_q;
    iter_d      = iter_q;
    early_en_d  = early_en_q;
    half_d      = half_q;
    early_d     = early_q;
    prev_hard_d = prev_hard_q;
    hard_d      = hard_q;

    case (state_q)
      turbo_pkg::IDLE: begin
        if (start_i) begin
          lim_d       = lim_in;
          early_en_d  = early_stop_en_i;
          iter_d      = '0;
          half_d      = 1'b0;
          early_d     = 1'b0;
          prev_hard_d = '0;
          state_d     = turbo_pkg::ISSUE;
        end
      end
      turbo_pkg::ISSUE: state_d = turbo_pkg::WAIT;
      turbo_pkg::WAIT: begin
        if (siso_finish_i) state_d = turbo_pkg::UPDATE;
      end
      turbo_pkg::UPDATE: begin
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = turbo_pkg::ISSUE;
        end else begin
          iter_d      = iter_inc;
          hard_d      = hard_new;
          prev_hard_d = hard_new;
          // Early stop needs a previous DEC2 result to compare against.
          if (early_en_q && (iter_q != '0) && (hard_new == prev_hard_q)) begin
            early_d = 1'b1;
            state_d = turbo_pkg::FINISH;
          end else if (iter_inc == lim_q) begin
            state_d = turbo_pkg::FINISH;
          end else begin
            half_d  = 1'b0;
            state_d = turbo_pkg::ISSUE;
          end
        end
      end
      turbo_pkg::FINISH: state_d = turbo_pkg::IDLE;
      default:           state_d = turbo_pkg::IDLE;
    endcase

    // Strobes are decoded from the next state so they align with it.
    siso_start_d = (state_d == turbo_pkg::ISSUE);
    ext_we_d     = (state_d == turbo_pkg::UPDATE);
    done_d       = (state_d == turbo_pkg::FINISH);
    busy_d       = (state_d != turbo_pkg::IDLE);
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= turbo_pkg::IDLE;
      lim_q        <= '0;
      iter_q       <= '0;
      early_en_q   <= 1'b0;
      half_q       <= 1'b0;
      early_q      <= 1'b0;
      prev_hard_q  <= '0;
      hard_q       <= '0;
      siso_start_q <= 1'b0;
      ext_we_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lim_q        <= lim_d;
      iter_q       <= iter_d;
      early_en_q   <= early_en_d;
      half_q       <= half_d;
      early_q      <= early_d;
      prev_hard_q  <= prev_hard_d;
      hard_q       <= hard_d;
      siso_start_q <= siso_start_d;
      ext_we_q     <= ext_we_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign siso_start_o = siso_start_q;
  assign half_sel_o   = half_q;
  assign ext_we_o     = ext_we_q;
  assign hard_o       = hard_q;
  assign iter_o       = iter_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign early_o      = early_q;

endmodule

// File: doc/turbo_iter_ctrl.md
# turbo_iter_ctrl

Iteration scheduler for the turbo decoder's single shared SISO engine. It sequences the half-iterations: DEC1 runs in natural order and DEC2 in interleaved order. For each half-iteration it issues the start pulse, waits for the SISO finish, and strobes the extrinsic-LLR capture. It counts full iterations against a programmable limit and can terminate early when hard decisions stop changing. It sits between the decoder top-level (start/done) and the SISO/extrinsic-buffer datapath.

## Interface
Parameters:
- MAX_ITER, 16: hard ceiling on full iterations (one iteration = DEC1 + DEC2).
- N_BITS, 7: LLR fields per block (5 data + 2 tail).
- LLR_W, 10: width of one LLR field, two's complement.
- ITER_W, 5: width of iteration counters; must hold MAX_ITER.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start a decode; sampled only in IDLE.
- max_iter_i  in  ITER_W  iteration limit, sampled with start_i.
- early_stop_en_i  in  1  enable hard-decision early termination, sampled with start_i.
- siso_start_o  out  1  one-cycle pulse that launches the SISO.
- siso_finish_i  in  1  SISO completion pulse.
- siso_llr_i  in  N_BITS*LLR_W  SISO a-posteriori LLRs; field 0 = MSBs.
- half_sel_o  out  1  0 = DEC1 (natural order), 1 = DEC2 (interleaved order).
- ext_we_o  out  1  one-cycle strobe; datapath latches new extrinsic values.
- hard_o  out  N_BITS  latest DEC2 hard decisions; bit N_BITS-1-i = sign bit of field i.
- iter_o  out  ITER_W  completed full iterations.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle pulse at decode end.
- early_o  out  1  high with done_o when the early stop fired; holds until the next start.

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, FINISH.
- IDLE, start_i=1:
  - Latch lim = clamp(max_iter_i, 1, MAX_ITER); a value of 0 gives 1.
  - Latch the early-stop enable.
  - Clear iter_o, half_sel_o, early_o and the previous-hard register.
  - Go to ISSUE.
- ISSUE: siso_start_o=1 for exactly this cycle, then go to WAIT.
- WAIT: stay until siso_finish_i=1, then go to UPDATE.
- UPDATE: ext_we_o=1 for this cycle, then branch on half_sel_o:
  - half_sel_o=0: set half_sel_o=1, go to ISSUE.
  - half_sel_o=1:
    - Compute hard_new = sign bits of siso_llr_i.
    - iter_o += 1.
    - If early enable and iter_o (old value) ≥ 1 and hard_new == prev_hard: set early_o=1, go to FINISH.
    - Else if iter_o+1 == lim: go to FINISH.
    - Else: half_sel_o=0, go to ISSUE.
    - In every case, hard_o and prev_hard are loaded with hard_new.
- FINISH: done_o=1 for one cycle, then go to IDLE. No half-iteration is ever aborted.
- Ignored inputs:
  - start_i in any state other than IDLE.
  - siso_finish_i outside WAIT.
  - siso_llr_i except in UPDATE while half_sel_o=1.
- Simultaneous start_i and done_o cannot occur: FINISH is not IDLE.
- Counter arithmetic is unsigned. iter_o never exceeds lim, so it cannot wrap.
- Reset, including mid-decode: immediately return to IDLE. Every output resets to 0 and all internal registers clear. The next decode starts only after a fresh start_i.

## Timing
- All outputs are registered.
- start_i high at cycle 0 → siso_start_o high at cycle 1.
- siso_finish_i high at cycle t in WAIT:
  - ext_we_o high at cycle t+1.
  - Then either siso_start_o high at t+2, or done_o high at t+2 with busy_o low from t+3.
- A new start_i is accepted at t+3.
- Controller overhead per half-iteration: 3 cycles plus SISO latency.

## Structure
- Shared package turbo_pkg holds:
  - the state enum (IDLE..FINISH);
  - the constants N_BITS, LLR_W, MAX_ITER, ITER_W;
  - the field-index helper for slicing the LLR bus (field i at bits [(N_BITS-i)*LLR_W-1 -: LLR_W]).
- One combinational sub-module, llr_sign_slicer: N_BITS*LLR_W LLR bus in, N_BITS sign bits out. It is reused by the output stage.

## Test plan
- max_iter_i=3, early off, SISO finish 10 cycles after each start:
  - Expect 6 siso_start_o pulses, with half_sel_o toggling 0,1,0,1,0,1.
  - Expect 6 ext_we_o pulses.
  - Expect done_o once, with iter_o=3 and early_o=0.
- max_iter_i=0 → exactly 2 half-iterations, iter_o=1.
- max_iter_i=31 → clamped to 16 iterations.
- Early on, DEC2 LLR signs identical in iterations 1 and 2 (hard=7'b1010100), max_iter_i=8:
  - done_o after iteration 2, iter_o=2, early_o=1, hard_o=7'b1010100.
- Extra conditions during a decode:
  - Stray siso_finish_i in ISSUE/UPDATE and start_i while busy → no state change, same pulse count as the clean run.
- Reset asserted in WAIT of the second DEC1:
  - All outputs 0 immediately.
  - A following start_i with max_iter_i=1 completes normally with iter_o=1.
